// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin grant arbiter with decoded
// active-low outputs.
package decoder_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    typedef logic [1:0] req_idx_t;

    localparam int unsigned MAX_HOLD_DEFAULT = 32'd8;

    // One-hot mask selecting a single requester.
    function automatic logic [3:0] idx_onehot(input req_idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/decoder_rr_arbiter_dec2to4_l.sv
// Active-low 2-to-4 decoder with active-low enable: one-cold output when
// enabled, all ones otherwise.
module dec2to4_l (
    input  logic       G_L,
    input  logic       A,
    input  logic       B,
    output logic [3:0] Y_L
);

    // Pure combinational decode of enable and select.
    always_comb begin
        Y_L = 4'b1111;
        if (G_L == 1'b0) begin
            Y_L[{B, A}] = 1'b0;
        end else begin
            Y_L = 4'b1111;
        end
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Four-requester round-robin arbiter with hold-time preemption, a one-cycle
// break-before-make gap and an active-low decoded grant.
module decoder_rr_arbiter
    import decoder_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    output logic       G_L,
    output logic       A,
    output logic       B,
    output logic [3:0] Y_L,
    output logic       BUSY
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    arb_state_e state_r, state_s;
    req_idx_t   owner_r, owner_s;
    req_idx_t   ptr_r, ptr_s;
    logic [7:0] hold_cnt_r, hold_cnt_s;
    logic       g_l_r, g_l_s;
    logic       busy_r, busy_s;

    req_idx_t   rr_cand_s;
    req_idx_t   rr_winner_s;
    logic       rr_found_s;
    logic       owner_req_s;
    logic       others_req_s;
    logic       at_max_s;

    // Round-robin search starting one past the last owner and wrapping.
    always_comb begin
        rr_found_s  = 1'b0;
        rr_winner_s = ptr_r;
        rr_cand_s   = ptr_r;
        for (int k = 1; k <= 4; k++) begin
            rr_cand_s = ptr_r + 2'(k);
            if (!rr_found_s && REQ[rr_cand_s]) begin
                rr_found_s  = 1'b1;
                rr_winner_s = rr_cand_s;
            end else begin
                rr_found_s  = rr_found_s;
            end
        end
    end

    assign owner_req_s  = REQ[owner_r];
    assign others_req_s = |(REQ & ~idx_onehot(owner_r));
    assign at_max_s     = (hold_cnt_r == HOLD_MAX);

    // Next-state and next-output logic.
    always_comb begin
        state_s    = state_r;
        owner_s    = owner_r;
        ptr_s      = ptr_r;
        hold_cnt_s = hold_cnt_r;
        g_l_s      = 1'b1;
        busy_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (rr_found_s) begin
                    state_s    = GRANT;
                    owner_s    = rr_winner_s;
                    ptr_s      = rr_winner_s;
                    hold_cnt_s = 8'd1;
                    g_l_s      = 1'b0;
                    busy_s     = 1'b1;
                end else begin
                    state_s    = IDLE;
                end
            end
            GRANT: begin
                // Owner drop and preemption collapse into the same single release.
                if (!owner_req_s || (at_max_s && others_req_s)) begin
                    state_s = GAP;
                    g_l_s   = 1'b1;
                    busy_s  = 1'b1;
                end else begin
                    state_s = GRANT;
                    g_l_s   = 1'b0;
                    busy_s  = 1'b1;
                    if (!at_max_s) begin
                        hold_cnt_s = hold_cnt_r + 8'd1;
                    end else begin
                        hold_cnt_s = hold_cnt_r;
                    end
                end
            end
            GAP: begin
                state_s = IDLE;
                g_l_s   = 1'b1;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = IDLE;
                g_l_s   = 1'b1;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears the grant asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r    <= IDLE;
            owner_r    <= 2'd0;
            ptr_r      <= 2'd3;
            hold_cnt_r <= 8'd0;
            g_l_r      <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            owner_r    <= owner_s;
            ptr_r      <= ptr_s;
            hold_cnt_r <= hold_cnt_s;
            g_l_r      <= g_l_s;
            busy_r     <= busy_s;
        end
    end

    assign G_L  = g_l_r;
    assign A    = owner_r[0];
    assign B    = owner_r[1];
    assign BUSY = busy_r;

    dec2to4_l u_dec (
        .G_L (g_l_r),
        .A   (owner_r[0]),
        .B   (owner_r[1]),
        .Y_L (Y_L)
    );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Table-driven bench for decoder_rr_arbiter (MAX_HOLD=4) with a scoreboard
// queue of expected post-edge outputs.
module tb_decoder_rr_arbiter;

    logic       CLK;
    logic       RST;
    logic [3:0] REQ;
    logic       G_L;
    logic       A;
    logic       B;
    logic [3:0] Y_L;
    logic       BUSY;

    typedef struct {
        logic [3:0] req;
        logic [3:0] y_l;
        logic       g_l;
        logic       busy;
        logic [1:0] ba;
        logic       ba_chk;
    } vec_t;

    vec_t vec_q[$];
    vec_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    decoder_rr_arbiter #(.MAX_HOLD(4)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .REQ  (REQ),
        .G_L  (G_L),
        .A    (A),
        .B    (B),
        .Y_L  (Y_L),
        .BUSY (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic add_g(input logic [3:0] req, input int idx);
        vec_t v;
        logic [3:0] one;
        one      = 4'b0001;
        v.req    = req;
        v.y_l    = ~(one << idx);
        v.g_l    = 1'b0;
        v.busy   = 1'b1;
        v.ba     = 2'(idx);
        v.ba_chk = 1'b1;
        vec_q.push_back(v);
    endtask

    task automatic add_p(input logic [3:0] req, input int idx);
        vec_t v;
        v.req    = req;
        v.y_l    = 4'b1111;
        v.g_l    = 1'b1;
        v.busy   = 1'b1;
        v.ba     = 2'(idx);
        v.ba_chk = 1'b1;
        vec_q.push_back(v);
    endtask

    task automatic add_i(input logic [3:0] req);
        vec_t v;
        v.req    = req;
        v.y_l    = 4'b1111;
        v.g_l    = 1'b1;
        v.busy   = 1'b0;
        v.ba     = 2'd0;
        v.ba_chk = 1'b0;
        vec_q.push_back(v);
    endtask

    task automatic compare(input string name, input int step);
        vec_t e;
        logic [7:0] act, exp, mask;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s step=%0d scoreboard empty", name, step);
        end else begin
            e    = sb_q.pop_front();
            act  = {G_L, BUSY, B, A, Y_L};
            exp  = {e.g_l, e.busy, e.ba, e.y_l};
            mask = e.ba_chk ? 8'hFF : 8'b1100_1111;
            checks++;
            if ((act & mask) !== (exp & mask)) begin
                failures++;
                $display("FAIL %s step=%0d got G_L=%b BUSY=%b BA=%b Y_L=%b want G_L=%b BUSY=%b BA=%b Y_L=%b",
                         name, step, G_L, BUSY, {B, A}, Y_L, e.g_l, e.busy, e.ba, e.y_l);
            end
        end
    endtask

    // Drive one vector, let one edge pass, then compare away from the edge.
    task automatic step_vec(input string name, input int idx, input vec_t v);
        REQ = v.req;
        sb_q.push_back(v);
        @(posedge CLK);
        #1;
        compare(name, idx);
    endtask

    vec_t rv;

    initial begin
        RST = 1'b1;
        REQ = 4'b1111;

        // Reset held with every request active.
        repeat (2) @(posedge CLK);
        #1;
        rv.req = 4'b1111; rv.y_l = 4'b1111; rv.g_l = 1'b1; rv.busy = 1'b0;
        rv.ba = 2'd0; rv.ba_chk = 1'b1;
        sb_q.push_back(rv);
        compare("reset_hold", 0);
        @(negedge CLK);
        RST = 1'b0;

        // Rotation: each owner drops after two grant cycles.
        add_g(4'b1111, 0); add_g(4'b1111, 0); add_p(4'b1110, 0); add_i(4'b1111);
        add_g(4'b1111, 1); add_g(4'b1111, 1); add_p(4'b1101, 1); add_i(4'b1111);
        add_g(4'b1111, 2); add_g(4'b1111, 2); add_p(4'b1011, 2); add_i(4'b1111);
        add_g(4'b1111, 3); add_g(4'b1111, 3); add_p(4'b0111, 3); add_i(4'b1111);
        add_g(4'b1111, 0); add_p(4'b0000, 0); add_i(4'b0000); add_i(4'b0000);
        // Preemption of owner 1 after four grant cycles.
        add_g(4'b0010, 1); add_g(4'b0110, 1); add_g(4'b0110, 1); add_g(4'b0110, 1);
        add_p(4'b0110, 1); add_i(4'b0110); add_g(4'b0110, 2);
        add_p(4'b0000, 2); add_i(4'b0000);
        // Saturation on requester 3, then preemption at the saturated count.
        add_g(4'b1000, 3);
        for (int i = 0; i < 20; i++) add_g(4'b1000, 3);
        add_p(4'b1001, 3); add_i(4'b1001);
        // Wrap: pointer at 3, requesters 0 and 3 pending -> 0 wins.
        add_g(4'b1001, 0); add_p(4'b0000, 0); add_i(4'b0000);
        // Owner drop coinciding with preemption yields a single gap.
        add_g(4'b0001, 0); add_g(4'b0001, 0); add_g(4'b0001, 0); add_g(4'b0001, 0);
        add_p(4'b0010, 0); add_i(4'b0010); add_g(4'b0010, 1); add_g(4'b0010, 1);

        for (int i = 0; i < vec_q.size(); i++) begin
            step_vec("table", i + 1, vec_q[i]);
        end

        // Asynchronous reset between edges while owner 1 holds the grant.
        #3;
        RST = 1'b1;
        #1;
        rv.req = 4'b0010; rv.y_l = 4'b1111; rv.g_l = 1'b1; rv.busy = 1'b0;
        rv.ba = 2'd0; rv.ba_chk = 1'b1;
        sb_q.push_back(rv);
        compare("async_reset", 0);
        REQ = 4'b1111;
        #2;
        RST = 1'b0;
        rv.req = 4'b1111; rv.y_l = 4'b1110; rv.g_l = 1'b0; rv.busy = 1'b1;
        rv.ba = 2'd0; rv.ba_chk = 1'b1;
        step_vec("post_reset_ptr", 1, rv);

        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder_rr_arbiter.md
DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive grant cycles before preemption when other requests are pending (range 2..255).
REQ-002 Port: CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: RST  input  1  reset; asynchronous, active-high.
REQ-004 Port: REQ  input  4  request lines, active-high, one per requester 0..3.
REQ-005 Port: G_L  output  1  active-low enable for the 2-to-4 decoder; 0 only while a grant is held.
REQ-006 Port: A  output  1  grant index bit 0 (LSB).
REQ-007 Port: B  output  1  grant index bit 1 (MSB).
REQ-008 Port: Y_L  output  4  active-low one-cold grant; Y_L[i]=0 iff G_L=0 and {B,A}=i.
REQ-009 Port: BUSY  output  1  high in GRANT and GAP states.

Function
REQ-010 The FSM SHALL have three states: IDLE, GRANT, GAP.
REQ-011 IDLE: if any REQ bit is high, the block SHALL select the winner by round-robin and enter GRANT on the next edge; otherwise it stays in IDLE.
REQ-012 Round-robin: search order starts at PTR+1 mod 4 and wraps (e.g. PTR=2 -> order 3,0,1,2); the first requester with REQ high wins.
REQ-013 On entering GRANT, the block SHALL register the winner index into {B,A}, drive G_L=0, set PTR to the winner and load HOLD_CNT=1.
REQ-014 Latency: REQ sampled high in IDLE at edge n SHALL produce G_L=0 and Y_L valid immediately after edge n+1 (1 cycle).
REQ-015 GRANT: HOLD_CNT SHALL increment each cycle, saturating at MAX_HOLD.
REQ-016 GRANT: the grant SHALL release (go to GAP) when REQ[owner] is low at an edge.
REQ-017 GRANT: the grant SHALL also release when HOLD_CNT=MAX_HOLD and any other REQ bit is high (preemption).
REQ-018 GRANT: when HOLD_CNT=MAX_HOLD and no other REQ is high, the block SHALL keep the grant with HOLD_CNT saturated.
REQ-019 GAP: exactly one cycle with G_L=1 and Y_L=4'b1111 (break-before-make); {B,A} SHALL hold the previous owner; next state is IDLE.
REQ-020 Simultaneous owner-drop and preemption in the same cycle SHALL be treated as a single release (one GAP cycle).
REQ-021 Y_L SHALL be a pure combinational decode of the registered G_L, B, A; no glitch-free guarantee is beyond registered inputs.
REQ-022 REQ changes of non-owners during GRANT SHALL have no effect until the next IDLE arbitration.
REQ-023 Minimum spacing between successive grants SHALL be 2 cycles of G_L=1 (GAP + IDLE).

Reset
REQ-024 While RST=1: state=IDLE, G_L=1, A=0, B=0, Y_L=4'b1111, BUSY=0, HOLD_CNT=0, PTR=3 (requester 0 highest priority first).
REQ-025 RST asserted mid-GRANT SHALL drop G_L to 1 asynchronously, with no GAP cycle.
REQ-026 The first arbitration SHALL happen at the first rising edge after RST deasserts.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE, GRANT, GAP), the 2-bit requester-index type and the default MAX_HOLD constant.
REQ-028 The active-low 2-to-4 decode SHALL be one sub-module, dec2to4_l (inputs G_L, A, B; output Y_L[3:0]); the rest is flat.
REQ-029 The round-robin search SHALL be combinational logic inside the top module, using no priority encoder sub-module.

Verification
REQ-030 Reset: RST=1 with REQ=4'b1111 -> G_L=1, Y_L=1111, BUSY=0; after release, first grant goes to requester 0 (Y_L=1110) one cycle later.
REQ-031 Rotation: REQ held 4'b1111, owners drop after 2 cycles each -> grant order 0,1,2,3,0 with G_L=0 two cycles then GAP+IDLE between.
REQ-032 Preemption: MAX_HOLD=4, REQ[1] held, REQ[2] raised at cycle 2 -> owner 1 released after 4 grant cycles, GAP, IDLE, then Y_L=1011.
REQ-033 Saturation: MAX_HOLD=4, only REQ[3] high for 20 cycles -> continuous grant, Y_L=0111 throughout, HOLD_CNT stays at 4.
REQ-034 Async reset mid-grant: RST pulsed between edges during GRANT -> G_L=1 and Y_L=1111 before the next edge; PTR=3 afterwards.
REQ-035 Wrap: PTR=3 after owner 3, REQ=4'b1001 -> next grant goes to 0, not 3.
